alu_issue_ctrl: RTL and testbench

- Issue-side controller that drives the core ALU.
- Accepts one decoded ALU instruction per valid/ready handshake and reads source operands from the register file.
- Drives the ALU output-select code and operand buses, captures the ALU result, and writes it back:
  - compare result goes to the register file;
  - jump result goes to the program counter.
- Sits between the instruction decoder and the ALU inside bb_core.

---
 rtl/alu_issue_ctrl_pkg.sv | 39 +++
 rtl/alu_issue_ctrl.sv | 167 ++++++++++++++++
 tb/tb_alu_issue_ctrl.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_issue_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : alu_issue_ctrl_pkg
//  Brief    : Shared definitions for the ALU issue controller. Holds the data
//             width, the ALU output-select codes shared with the ALU, the
//             opcode constants and the controller state encoding.
//  Revision : 1.0 - initial release
// ============================================================================
package alu_issue_ctrl_pkg;

  localparam int DATA_WIDTH = 8;

  // ALU output-select codes; any other value makes the ALU output zero
  localparam logic [5:0] ALU_NONE      = 6'b000000;
  localparam logic [5:0] ALU_COMPARER  = 6'b000001;
  localparam logic [5:0] ALU_JUMP_COND = 6'b000010;

  // Decoded opcodes; 2 and 3 are illegal
  localparam logic [1:0] OP_CMP = 2'd0;
  localparam logic [1:0] OP_JMP = 2'd1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    EXEC = 2'd2,
    WB   = 2'd3
  } state_t;

  // Map an opcode to the ALU output-select code driven during EXEC
  function automatic logic [5:0] op_to_sel(input logic [1:0] op);
    case (op)
      OP_CMP:  op_to_sel = ALU_COMPARER;
      OP_JMP:  op_to_sel = ALU_JUMP_COND;
      default: op_to_sel = ALU_NONE;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/alu_issue_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : alu_issue_ctrl
//  Brief    : Issue-side controller for the core ALU. Takes one decoded
//             instruction per handshake, reads operands from the register
//             file, drives the ALU, captures its result and writes it back
//             to the register file (compare) or the program counter (jump).
//             Sequence IDLE -> READ -> EXEC -> WB, one instruction per four
//             cycles.
//  Options  : ALU_ISSUE_ZERO_REG_EN - register 0 reads as zero and a compare
//             targeting register 0 produces no write strobe.
//  Revision : 1.0 - initial release
// ============================================================================
module alu_issue_ctrl
  import alu_issue_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH     = alu_issue_ctrl_pkg::DATA_WIDTH,
  parameter int REG_ADDR_WIDTH = 3
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      i_instr_valid,
  output logic                      o_instr_ready,
  input  logic [1:0]                i_opcode,
  input  logic [REG_ADDR_WIDTH-1:0] i_src0,
  input  logic [REG_ADDR_WIDTH-1:0] i_src1,
  input  logic [REG_ADDR_WIDTH-1:0] i_dst,
  input  logic [DATA_WIDTH-1:0]     i_direct_addr,
  input  logic [DATA_WIDTH-1:0]     i_program_addr,
  output logic [REG_ADDR_WIDTH-1:0] o_rf_raddr0,
  output logic [REG_ADDR_WIDTH-1:0] o_rf_raddr1,
  input  logic [DATA_WIDTH-1:0]     i_rf_rdata0,
  input  logic [DATA_WIDTH-1:0]     i_rf_rdata1,
  output logic [5:0]                o_unit_alu_output_en,
  output logic [DATA_WIDTH-1:0]     o_perand0,
  output logic [DATA_WIDTH-1:0]     o_perand1,
  output logic [DATA_WIDTH-1:0]     o_direct_addr,
  output logic [DATA_WIDTH-1:0]     o_program_addr,
  input  logic [DATA_WIDTH-1:0]     i_alu_output,
  output logic                      o_rf_we,
  output logic [REG_ADDR_WIDTH-1:0] o_rf_waddr,
  output logic [DATA_WIDTH-1:0]     o_rf_wdata,
  output logic                      o_pc_load,
  output logic [DATA_WIDTH-1:0]     o_pc_value,
  output logic                      o_illegal,
  output logic                      o_busy
);

  state_t                    r_state;
  state_t                    w_state_next;
  logic                      w_accept;
  logic                      w_cmp_we;
  logic [1:0]                r_opcode;
  logic [REG_ADDR_WIDTH-1:0] r_src0;
  logic [REG_ADDR_WIDTH-1:0] r_src1;
  logic [REG_ADDR_WIDTH-1:0] r_dst;
  logic [DATA_WIDTH-1:0]     r_direct_addr;
  logic [DATA_WIDTH-1:0]     r_program_addr;
  logic [DATA_WIDTH-1:0]     r_operand0;
  logic [DATA_WIDTH-1:0]     r_operand1;
  logic [DATA_WIDTH-1:0]     r_result;

  assign w_accept = i_instr_valid && (r_state == IDLE);

  // A compare writes back unless register 0 is hardwired and is the target
`ifdef ALU_ISSUE_ZERO_REG_EN
  assign w_cmp_we = (r_opcode == OP_CMP) && (r_dst != '0);
`else
  assign w_cmp_we = (r_opcode == OP_CMP);
`endif

  // State register; reset drops any in-flight instruction
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next state and decoded outputs; strobes are only ever raised in WB
  always_comb begin
    w_state_next         = r_state;
    o_instr_ready        = 1'b0;
    o_unit_alu_output_en = ALU_NONE;
    o_rf_we              = 1'b0;
    o_pc_load            = 1'b0;
    o_illegal            = 1'b0;
    o_rf_raddr0          = r_src0;
    o_rf_raddr1          = r_src1;
    case (r_state)
      IDLE: begin
        o_instr_ready = 1'b1;
        // The register file reads synchronously, so the address must be
        // presented in the handshake cycle for data to arrive in READ
        o_rf_raddr0   = i_src0;
        o_rf_raddr1   = i_src1;
        if (w_accept) begin
          w_state_next = READ;
        end
      end
      READ: begin
        w_state_next = EXEC;
      end
      EXEC: begin
        o_unit_alu_output_en = op_to_sel(r_opcode);
        w_state_next         = WB;
      end
      WB: begin
        o_rf_we      = w_cmp_we;
        o_pc_load    = (r_opcode == OP_JMP);
        o_illegal    = (r_opcode != OP_CMP) && (r_opcode != OP_JMP);
        w_state_next = IDLE;
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  // Instruction fields, operands and ALU result latched as the sequence advances
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_opcode       <= '0;
      r_src0         <= '0;
      r_src1         <= '0;
      r_dst          <= '0;
      r_direct_addr  <= '0;
      r_program_addr <= '0;
      r_operand0     <= '0;
      r_operand1     <= '0;
      r_result       <= '0;
    end else begin
      if (w_accept) begin
        r_opcode       <= i_opcode;
        r_src0         <= i_src0;
        r_src1         <= i_src1;
        r_dst          <= i_dst;
        r_direct_addr  <= i_direct_addr;
        r_program_addr <= i_program_addr;
      end
      if (r_state == READ) begin
`ifdef ALU_ISSUE_ZERO_REG_EN
        r_operand0 <= (r_src0 == '0) ? '0 : i_rf_rdata0;
        r_operand1 <= (r_src1 == '0) ? '0 : i_rf_rdata1;
`else
        r_operand0 <= i_rf_rdata0;
        r_operand1 <= i_rf_rdata1;
`endif
      end
      if (r_state == EXEC) begin
        r_result <= i_alu_output;
      end
    end
  end

  assign o_perand0      = r_operand0;
  assign o_perand1      = r_operand1;
  assign o_direct_addr  = r_direct_addr;
  assign o_program_addr = r_program_addr;
  assign o_rf_waddr     = r_dst;
  assign o_rf_wdata     = r_result;
  assign o_pc_value     = r_result;
  assign o_busy         = (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_alu_issue_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_issue_ctrl
//  Brief    : Self-checking bench for alu_issue_ctrl with a register-file and
//             ALU model. Expected writebacks are queued at issue and popped by
//             a monitor whenever a strobe appears.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_alu_issue_ctrl;

  localparam int DW = 8;
  localparam int AW = 3;

  logic          clk;
  logic          rst_n;
  logic          instr_valid;
  logic          instr_ready;
  logic [1:0]    opcode;
  logic [AW-1:0] src0, src1, dst;
  logic [DW-1:0] direct_addr_in, program_addr_in;
  logic [AW-1:0] rf_raddr0, rf_raddr1;
  logic [DW-1:0] rf_rdata0, rf_rdata1;
  logic [5:0]    alu_en;
  logic [DW-1:0] perand0, perand1, direct_addr_out, program_addr_out;
  logic [DW-1:0] alu_output;
  logic          rf_we;
  logic [AW-1:0] rf_waddr;
  logic [DW-1:0] rf_wdata;
  logic          pc_load;
  logic [DW-1:0] pc_value;
  logic          illegal;
  logic          busy;

  alu_issue_ctrl #(.DATA_WIDTH(DW), .REG_ADDR_WIDTH(AW)) dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .i_instr_valid        (instr_valid),
    .o_instr_ready        (instr_ready),
    .i_opcode             (opcode),
    .i_src0               (src0),
    .i_src1               (src1),
    .i_dst                (dst),
    .i_direct_addr        (direct_addr_in),
    .i_program_addr       (program_addr_in),
    .o_rf_raddr0          (rf_raddr0),
    .o_rf_raddr1          (rf_raddr1),
    .i_rf_rdata0          (rf_rdata0),
    .i_rf_rdata1          (rf_rdata1),
    .o_unit_alu_output_en (alu_en),
    .o_perand0            (perand0),
    .o_perand1            (perand1),
    .o_direct_addr        (direct_addr_out),
    .o_program_addr       (program_addr_out),
    .i_alu_output         (alu_output),
    .o_rf_we              (rf_we),
    .o_rf_waddr           (rf_waddr),
    .o_rf_wdata           (rf_wdata),
    .o_pc_load            (pc_load),
    .o_pc_value           (pc_value),
    .o_illegal            (illegal),
    .o_busy               (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Register file model: synchronous read, write on strobe
  logic [DW-1:0] rf [8];
  initial begin
    rf[0] = 8'hFF; rf[1] = 8'h05; rf[2] = 8'h09; rf[3] = 8'h33;
    rf[4] = 8'h44; rf[5] = 8'h55; rf[6] = 8'h66; rf[7] = 8'h77;
  end
  always @(posedge clk) begin
    rf_rdata0 <= rf[rf_raddr0];
    rf_rdata1 <= rf[rf_raddr1];
    if (rf_we) rf[rf_waddr] <= rf_wdata;
  end

  // ALU model: compare gives {lt, eq}, jump passes the direct address
  always_comb begin
    alu_output = '0;
    case (alu_en)
      6'b000001: alu_output = {6'b0, perand0 < perand1, perand0 == perand1};
      6'b000010: alu_output = direct_addr_out;
      default:   alu_output = '0;
    endcase
  end

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Scoreboard entry: kind 0=rf write, 1=pc load, 2=illegal
  typedef struct {
    int         kind;
    logic [2:0] addr;
    logic [7:0] data;
    int         cyc;
  } exp_t;
  exp_t sb[$];

  // Monitor: any strobe must match the oldest expected writeback
  always @(negedge clk) begin
    if (rst_n && (rf_we || pc_load || illegal)) begin
      check("strobe_onehot", int'(rf_we) + int'(pc_load) + int'(illegal), 1);
      if (sb.size() == 0) begin
        check("unexpected_strobe", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("wb_kind", rf_we ? 0 : (pc_load ? 1 : 2), e.kind);
        check("wb_latency", cyc, e.cyc);
        if (e.kind == 0) begin
          check("wb_waddr", int'(rf_waddr), int'(e.addr));
          check("wb_wdata", int'(rf_wdata), int'(e.data));
        end else if (e.kind == 1) begin
          check("wb_pc_value", int'(pc_value), int'(e.data));
        end
      end
    end
  end

  // Issue one instruction, check EXEC buses, optionally queue the writeback
  task automatic run(input logic [1:0] op, input logic [2:0] s0, input logic [2:0] s1,
                     input logic [2:0] d, input logic [7:0] da, input logic [7:0] pa,
                     input logic [5:0] exp_en, input logic [7:0] exp_p0,
                     input logic [7:0] exp_p1, input int kind, input logic [7:0] exp_data,
                     input bit push);
    exp_t e;
    @(negedge clk);
    opcode = op; src0 = s0; src1 = s1; dst = d;
    direct_addr_in = da; program_addr_in = pa;
    instr_valid = 1'b1;
    check("hs_ready", int'(instr_ready), 1);
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
    if (push) begin
      e.kind = kind; e.addr = d; e.data = exp_data; e.cyc = cyc + 2;
      sb.push_back(e);
    end
    check("read_ready_low", int'(instr_ready), 0);
    @(posedge clk);
    #1;
    check("exec_alu_en", int'(alu_en), int'(exp_en));
    check("exec_perand0", int'(perand0), int'(exp_p0));
    check("exec_perand1", int'(perand1), int'(exp_p1));
    if (op == 2'd1) begin
      check("exec_direct_addr", int'(direct_addr_out), int'(da));
      check("exec_program_addr", int'(program_addr_out), int'(pa));
    end
    @(posedge clk);
    #1;
    check("wb_alu_en_off", int'(alu_en), 0);
    if (!push) check("wb_no_rf_we", int'(rf_we), 0);
    @(posedge clk);
    #1;
    check("idle_ready", int'(instr_ready), 1);
  endtask

  initial begin
    exp_t e;
    int   hs_a;
    int   lows;
    rst_n = 1'b0; instr_valid = 1'b0; opcode = '0;
    src0 = '0; src1 = '0; dst = '0; direct_addr_in = '0; program_addr_in = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", int'(instr_ready), 1);
    check("rst_busy", int'(busy), 0);
    check("rst_alu_en", int'(alu_en), 0);
    check("rst_rf_we", int'(rf_we), 0);
    check("rst_pc_load", int'(pc_load), 0);
    check("rst_illegal", int'(illegal), 0);
    check("rst_perand0", int'(perand0), 0);
    rst_n = 1'b1;

    // Compare R1=5 vs R2=9 -> lt -> 8'h02 into R3
    run(2'd0, 3'd1, 3'd2, 3'd3, 8'h00, 8'h00, 6'b000001, 8'h05, 8'h09, 0, 8'h02, 1'b1);
    // Jump: ALU passes direct address 8'h40 to the PC
    run(2'd1, 3'd4, 3'd5, 3'd0, 8'h40, 8'h10, 6'b000010, 8'h44, 8'h55, 1, 8'h40, 1'b1);
    // Illegal opcode 3: select stays 0, illegal pulse only
    run(2'd3, 3'd6, 3'd7, 3'd2, 8'h00, 8'h00, 6'b000000, 8'h66, 8'h77, 2, 8'h00, 1'b1);
    // src0==src1==dst: 5 == 5 -> 8'h01 back into R1
    run(2'd0, 3'd1, 3'd1, 3'd1, 8'h00, 8'h00, 6'b000001, 8'h05, 8'h05, 0, 8'h01, 1'b1);
    // New R1=1 vs R3=2 -> lt -> 8'h02 into R5
    run(2'd0, 3'd1, 3'd3, 3'd5, 8'h00, 8'h00, 6'b000001, 8'h01, 8'h02, 0, 8'h02, 1'b1);

    // Back-to-back with valid held high
    @(negedge clk);
    opcode = 2'd0; src0 = 3'd2; src1 = 3'd4; dst = 3'd6;
    instr_valid = 1'b1;
    @(posedge clk);
    #1;
    hs_a = cyc;
    e.kind = 0; e.addr = 3'd6; e.data = 8'h02; e.cyc = cyc + 2;  // 9 < 0x44
    sb.push_back(e);
    opcode = 2'd1; src0 = 3'd3; src1 = 3'd3; direct_addr_in = 8'h80; program_addr_in = 8'h20;
    lows = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (!instr_ready) lows++;
    end
    check("b2b_ready_low_cycles", lows, 3);
    @(negedge clk);
    check("b2b_ready_back", int'(instr_ready), 1);
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
    check("b2b_hs_spacing", cyc - hs_a, 4);
    e.kind = 1; e.addr = 3'd6; e.data = 8'h80; e.cyc = cyc + 2;
    sb.push_back(e);
    repeat (4) @(posedge clk);
    #1;

    // Reset asserted during EXEC discards the compare
    @(negedge clk);
    opcode = 2'd0; src0 = 3'd1; src1 = 3'd2; dst = 3'd7; instr_valid = 1'b1;
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
    @(posedge clk);
    #1;
    check("mid_exec_alu_en", int'(alu_en), 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_alu_en", int'(alu_en), 0);
    check("mid_rst_busy", int'(busy), 0);
    check("mid_rst_perand0", int'(perand0), 0);
    check("mid_rst_rf_we", int'(rf_we), 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("post_rst_ready", int'(instr_ready), 1);
    check("post_rst_r7_intact", int'(rf[7]), 8'h77);

`ifdef ALU_ISSUE_ZERO_REG_EN
    // R0 reads as 0 despite rdata 8'hFF; 0 < 9 -> 2, but dst=0 suppresses write
    run(2'd0, 3'd0, 3'd2, 3'd0, 8'h00, 8'h00, 6'b000001, 8'h00, 8'h09, 0, 8'h02, 1'b0);
`else
    // R0 is ordinary: 0xFF vs 9 -> 0, written to R0
    run(2'd0, 3'd0, 3'd2, 3'd0, 8'h00, 8'h00, 6'b000001, 8'hFF, 8'h09, 0, 8'h00, 1'b1);
`endif

    repeat (4) @(posedge clk);
    #1;
    check("scoreboard_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  // Global time limit so the run always ends
  initial begin
    #100000;
    $display("FAIL timeout: reached time limit");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
